freq_meter_ctrl: RTL and testbench

//  Measurement sequencer for the lab1 frequency counter.
//  - Opens fixed-length gate windows on CLOCK_50 and counts rising edges of SMA_CLKIN (synchronised) into the external BCD counter.
//  - Latches each result to the HEX0..HEX7 display registers.
//  - KEY[0] toggles a display-hold mode.

---
 rtl/freq_meter_pkg.sv | 23 ++
 rtl/freq_meter_key_debounce.sv | 60 ++++++
 rtl/freq_meter_ctrl.sv | 125 ++++++++++++
 tb/tb_freq_meter_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and defaults for the frequency meter sequencer.
// The sticky-overflow option (FREQ_OVF_STICKY_EN) is handled in freq_meter_ctrl.
`timescale 1ns/1ps
package freq_meter_pkg;

  localparam int CLK_HZ              = 50_000_000;
  localparam int GATE_CYCLES_DEF     = 50_000_000;
  localparam int DEBOUNCE_CYCLES_DEF = 250_000;
  localparam int SYNC_STAGES_DEF     = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    GATE  = 2'd2,
    LATCH = 2'd3
  } state_t;

  // Counter width for a counter running 0..cycles-1; never narrower than 1 bit.
  function automatic int gate_w(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/freq_meter_key_debounce.sv
// Synchroniser plus stable-time debouncer for a low-active push button.
// Emits a single-cycle press pulse when a 1->0 change has been stable long enough.
`timescale 1ns/1ps
module key_debounce
  import freq_meter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic srst,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = gate_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic                   hist_reg;
  logic                   level_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   synced;
  logic                   stable;
  logic                   accept;

  assign sync_next[0] = key_n;
  for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync_shift
    assign sync_next[gi] = sync_reg[gi-1];
  end

  assign synced = sync_reg[SYNC_STAGES-1];
  assign stable = (synced == hist_reg);
  assign accept = stable && (synced != level_reg) && (cnt_reg == CNT_LAST);
  assign press  = accept && !synced;

  // The accepted level starts low, so the first event accepted after reset
  // is a release and can never be mistaken for a press.
  always_ff @(posedge clk) begin
    if (srst) begin
      sync_reg  <= '0;
      hist_reg  <= 1'b0;
      level_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync_reg <= sync_next;
      hist_reg <= synced;
      if (!stable || (synced == level_reg)) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        cnt_reg   <= '0;
        level_reg <= synced;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/freq_meter_ctrl.sv
// Gate-window sequencer for the frequency counter: IDLE -> CLEAR -> GATE -> LATCH loop.
// Define FREQ_OVF_STICKY_EN to keep ovf_flag set until reset or an accepted key press.
`timescale 1ns/1ps
module freq_meter_ctrl
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES     = GATE_CYCLES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic SMA_CLKIN,
  input  logic key_hold_n,
  input  logic cnt_ovf,
  output logic cnt_clr,
  output logic cnt_inc,
  output logic disp_load,
  output logic gate_active,
  output logic meas_done,
  output logic hold,
  output logic ovf_flag
);

  localparam int GATE_W = gate_w(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  state_t                 state_reg;
  state_t                 state_next;
  logic [GATE_W-1:0]      gate_cnt_reg;
  logic [SYNC_STAGES-1:0] sma_sync_reg;
  logic [SYNC_STAGES-1:0] sma_sync_next;
  logic                   sma_hist_reg;
  logic                   sma_rise;
  logic                   ovf_seen_reg;
  logic                   hold_reg;
  logic                   ovf_flag_reg;
  logic                   key_press;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_key_debounce (
    .clk   (CLOCK_50),
    .srst  (reset),
    .key_n (key_hold_n),
    .press (key_press)
  );

  assign sma_sync_next[0] = SMA_CLKIN;
  for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sma_shift
    assign sma_sync_next[gi] = sma_sync_reg[gi-1];
  end

  assign sma_rise = sma_sync_reg[SYNC_STAGES-1] & ~sma_hist_reg;

  always_comb begin
    state_next  = state_reg;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    disp_load   = 1'b0;
    gate_active = 1'b0;
    meas_done   = 1'b0;
    case (state_reg)
      IDLE:  state_next = CLEAR;
      CLEAR: begin
        cnt_clr    = 1'b1;
        state_next = GATE;
      end
      GATE: begin
        gate_active = 1'b1;
        cnt_inc     = sma_rise;
        if (gate_cnt_reg == GATE_LAST) state_next = LATCH;
      end
      LATCH: begin
        meas_done  = 1'b1;
        // A press landing this cycle only changes hold_reg at the clock edge,
        // so the current display load still sees the old hold value.
        disp_load  = ~hold_reg;
        state_next = CLEAR;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg    <= IDLE;
      gate_cnt_reg <= '0;
      sma_sync_reg <= '0;
      sma_hist_reg <= 1'b0;
      ovf_seen_reg <= 1'b0;
      hold_reg     <= 1'b0;
      ovf_flag_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sma_sync_reg <= sma_sync_next;
      sma_hist_reg <= sma_sync_reg[SYNC_STAGES-1];

      if (state_reg == CLEAR) begin
        gate_cnt_reg <= '0;
        ovf_seen_reg <= 1'b0;
      end else if (state_reg == GATE) begin
        gate_cnt_reg <= gate_cnt_reg + 1'b1;
        if (cnt_ovf) ovf_seen_reg <= 1'b1;
      end

      if (key_press) hold_reg <= ~hold_reg;

`ifdef FREQ_OVF_STICKY_EN
      if (key_press) begin
        ovf_flag_reg <= 1'b0;
      end else if (state_reg == LATCH) begin
        ovf_flag_reg <= ovf_flag_reg | ovf_seen_reg;
      end
`else
      if (state_reg == LATCH) ovf_flag_reg <= ovf_seen_reg;
`endif
    end
  end

  assign hold     = hold_reg;
  assign ovf_flag = ovf_flag_reg;

endmodule

// File: tb/tb_freq_meter_ctrl.sv
// Scoreboard bench for freq_meter_ctrl: stimulus pushes per-window expectations,
// a negedge monitor pops them whenever meas_done is presented.
`timescale 1ns/1ps
module tb_freq_meter_ctrl;

  localparam int GATE       = 1000;
  localparam int DEB        = 16;
  localparam int SYNC       = 2;
  localparam int WIN        = GATE + 2;
  localparam int GATE_NS    = GATE * 20;
  localparam int N_WINDOWS  = 14;
  localparam int ABORT_WIN  = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sma = 1'b0;
  logic key_n = 1'b1;
  logic cnt_ovf = 1'b0;
  logic cnt_clr, cnt_inc, disp_load, gate_active, meas_done, hold, ovf_flag;

  freq_meter_ctrl #(
    .GATE_CYCLES     (GATE),
    .DEBOUNCE_CYCLES (DEB),
    .SYNC_STAGES     (SYNC)
  ) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .SMA_CLKIN   (sma),
    .key_hold_n  (key_n),
    .cnt_ovf     (cnt_ovf),
    .cnt_clr     (cnt_clr),
    .cnt_inc     (cnt_inc),
    .disp_load   (disp_load),
    .gate_active (gate_active),
    .meas_done   (meas_done),
    .hold        (hold),
    .ovf_flag    (ovf_flag)
  );

  typedef struct {
    int min_inc;
    int max_inc;
    bit disp;
    bit hold;
    bit ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   mon_en  = 1'b0;
  int   sma_half = 31;
  int   prev_period = 62;
  bit   hold_m = 1'b0;
  bit   ovf_m  = 1'b0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Test signal, phase-shifted so its edges never coincide with a clock edge.
  initial begin
    #0.3;
    forever begin
      #(sma_half);
      sma = ~sma;
    end
  end

  task automatic check(input string name, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  // Monitor: accumulates per-window observations and checks them on meas_done.
  int   inc_cnt, gate_cnt, clr_cnt, stray_cnt, last_done;
  bit   ovf_pend, ovf_pend_val;
  exp_t mon_e;

  always @(negedge clk) begin
    if (!mon_en) begin
      inc_cnt = 0; gate_cnt = 0; clr_cnt = 0; stray_cnt = 0;
      last_done = -1; ovf_pend = 1'b0;
    end else begin
      if (ovf_pend) begin
        check("ovf_flag", ovf_flag, ovf_pend_val);
        ovf_pend = 1'b0;
      end
      if (gate_active) gate_cnt++;
      if (cnt_inc) begin
        if (gate_active) inc_cnt++;
        else stray_cnt++;
      end
      if (cnt_clr) clr_cnt++;
      if (disp_load && !meas_done) stray_cnt++;
      if (meas_done) begin
        check("pending_expectations", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check_range("inc_count", inc_cnt, mon_e.min_inc, mon_e.max_inc);
          check("disp_load", disp_load, mon_e.disp);
          check("hold", hold, mon_e.hold);
          ovf_pend     = 1'b1;
          ovf_pend_val = mon_e.ovf;
        end
        check("gate_len", gate_cnt, GATE);
        check("clr_pulses", clr_cnt, 1);
        check("stray_pulses", stray_cnt, 0);
        check("latch_gate_off", gate_active, 0);
        if (last_done >= 0) check("window_period", cyc - last_done, WIN);
        last_done = cyc;
        inc_cnt = 0; gate_cnt = 0; clr_cnt = 0; stray_cnt = 0;
      end
    end
  end

  // Holds reset for three edges, releases, and returns just after the edge into CLEAR.
  task automatic do_reset();
    mon_en = 1'b0;
    reset  = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("reset_outputs",
            {cnt_clr, cnt_inc, disp_load, gate_active, meas_done, hold, ovf_flag}, 0);
    end
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("idle_no_clear", cnt_clr, 0);
    check("idle_no_gate", gate_active, 0);
    @(posedge clk);
    #2;
  endtask

  // One full window starting in its CLEAR cycle (c=0); c=1..GATE are gate cycles, c=WIN-1 is LATCH.
  task automatic run_window(input int w, input bit abort);
    int   period, kmode, ovf_c, r, lo, hi;
    bit   ovf_this, tight;
    exp_t e;

    if (w < 5) begin
      period = 62;
      case (w)
        1:       begin kmode = 1; ovf_c = 500; end
        3:       begin kmode = 2; ovf_c = -1;  end
        4:       begin kmode = 1; ovf_c = -1;  end
        default: begin kmode = 0; ovf_c = -1;  end
      endcase
    end else begin
      period = ($urandom_range(0, 2) == 0) ? prev_period : 2 * int'($urandom_range(25, 150));
      kmode  = int'($urandom_range(0, 2));
      r      = int'($urandom_range(0, 3));
      case (r)
        0:       ovf_c = -1;
        1:       ovf_c = int'($urandom_range(1, GATE));
        2:       ovf_c = ($urandom_range(0, 1) == 0) ? 0 : WIN - 1;
        default: ovf_c = ($urandom_range(0, 1) == 0) ? 1 : GATE;
      endcase
    end
    if (abort) begin
      kmode = 0;
      ovf_c = -1;
    end

    tight       = (period == prev_period);
    prev_period = period;
    sma_half    = period / 2;
    lo = GATE_NS / period;
    hi = (GATE_NS + period - 1) / period;
    if (!tight) begin
      lo = lo - 2;
      hi = hi + 2;
    end

    ovf_this = (ovf_c >= 1) && (ovf_c <= GATE);
    if (kmode == 1) hold_m = !hold_m;
`ifdef FREQ_OVF_STICKY_EN
    ovf_m = ((kmode == 1) ? 1'b0 : ovf_m) | ovf_this;
`else
    ovf_m = ovf_this;
`endif
    e = '{lo, hi, !hold_m, hold_m, ovf_m};
    if (!abort) exp_q.push_back(e);

    mon_en = 1'b1;
    for (int c = 0; c < WIN; c++) begin
      key_n   = !((kmode == 1 && c >= 60 && c < 100) || (kmode == 2 && c >= 60 && c < 70));
      cnt_ovf = (c == ovf_c);
      if (abort && c == 501) begin
        mon_en = 1'b0;
        exp_q.delete();
        hold_m = 1'b0;
        ovf_m  = 1'b0;
        do_reset();
        return;
      end
      if (c == 0) begin
        @(negedge clk);
        check("clear_pulse", cnt_clr, 1);
        check("clear_gate_off", gate_active, 0);
      end
      @(posedge clk);
      #2;
    end
    cnt_ovf = 1'b0;
    key_n   = 1'b1;
  endtask

  initial begin
    do_reset();
    for (int w = 0; w < N_WINDOWS; w++) begin
      run_window(w, w == ABORT_WIN);
    end
    @(negedge clk);
    @(negedge clk);
    mon_en = 1'b0;
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: reached time limit at cycle %0d, expected completion before it", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
